// File: rtl/rf_pkg.sv
// Shared constants for the register-file execution controller:
// R-type opcode, funct7 values, ALU operation codes and FSM states.
package rf_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_BASE  = 7'h00;
    localparam logic [6:0] F7_ALT   = 7'h20;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/rf_exec_ctrl_if.sv
// Bundle between the controller and its environment: instruction
// handshake, regfile control/data, ALU operands/result and status.
// master = the controller, slave = instruction source + regfile + ALU.
interface rf_exec_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic [4:0]       rf_rs1;
    logic [4:0]       rf_rs2;
    logic [4:0]       rf_rd;
    logic             rf_we;
    logic [XLEN-1:0]  rf_wdata;
    logic [XLEN-1:0]  rf_rv1;
    logic [XLEN-1:0]  rf_rv2;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [3:0]       alu_ctrl;
    logic [XLEN-1:0]  alu_result;
    logic             done;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  instr_valid, instr, rf_rv1, rf_rv2, alu_result,
        output instr_ready, rf_rs1, rf_rs2, rf_rd, rf_we, rf_wdata,
               alu_a, alu_b, alu_ctrl, done, illegal, instr_count
    );

    modport slave (
        output instr_valid, instr, rf_rv1, rf_rv2, alu_result,
        input  instr_ready, rf_rs1, rf_rs2, rf_rd, rf_we, rf_wdata,
               alu_a, alu_b, alu_ctrl, done, illegal, instr_count
    );
endinterface

// File: rtl/rtype_decode.sv
// Combinational RV32 R-type decoder: opcode/funct fields -> ALU code
// plus a legal flag. Illegal encodings report ALU_ADD with legal=0.
module rtype_decode
    import rf_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] alu_ctrl_o,
    output logic       legal_o
);

    // Decode funct3/funct7; funct7 only disambiguates ADD/SUB and SRL/SRA.
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        legal_o    = 1'b0;
        if (opcode_i == OP_RTYPE) begin
            case (funct3_i)
                3'd0: begin
                    if (funct7_i == F7_BASE) begin
                        alu_ctrl_o = ALU_ADD;
                        legal_o    = 1'b1;
                    end else if (funct7_i == F7_ALT) begin
                        alu_ctrl_o = ALU_SUB;
                        legal_o    = 1'b1;
                    end
                end
                3'd1: begin alu_ctrl_o = ALU_SLL; legal_o = 1'b1; end
                3'd2: begin alu_ctrl_o = ALU_SLT; legal_o = 1'b1; end
                3'd4: begin alu_ctrl_o = ALU_XOR; legal_o = 1'b1; end
                3'd6: begin alu_ctrl_o = ALU_OR;  legal_o = 1'b1; end
                3'd7: begin alu_ctrl_o = ALU_AND; legal_o = 1'b1; end
                3'd5: begin
                    if (funct7_i == F7_BASE) begin
                        alu_ctrl_o = ALU_SRL;
                        legal_o    = 1'b1;
                    end else if (funct7_i == F7_ALT) begin
                        alu_ctrl_o = ALU_SRA;
                        legal_o    = 1'b1;
                    end
                end
                default: ; // funct3=3 (SLTU) is not supported
            endcase
        end
    end

endmodule

// File: rtl/rf_exec_ctrl.sv
// Four-state sequencer driving a registered-read regfile and an external
// combinational ALU: IDLE (accept) -> READ -> EXEC -> WB (write-back).
module rf_exec_ctrl
    import rf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rf_exec_ctrl_if.master bus
);

    state_e           state_q, state_d;
    logic [4:0]       rs1_q, rs2_q, rd_q;
    logic [3:0]       ctrl_q;
    logic             legal_q;
    logic [XLEN-1:0]  wdata_q, a_q, b_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0]       dec_ctrl;
    logic             dec_legal;
    logic             accept;

    rtype_decode u_dec (
        .opcode_i   (bus.instr[6:0]),
        .funct3_i   (bus.instr[14:12]),
        .funct7_i   (bus.instr[31:25]),
        .alu_ctrl_o (dec_ctrl),
        .legal_o    (dec_legal)
    );

    assign accept = (state_q == ST_IDLE) && bus.instr_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: fixed walk through all states once an instruction is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.instr_valid) state_d = ST_READ;
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath registers: fields and decode are latched at accept so the
    // read addresses are already on the bus during READ; operands and the
    // ALU result are captured at the end of EXEC. The counter moves at the
    // same edge so the new count is visible alongside done in WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= ALU_ADD;
            legal_q <= 1'b0;
            wdata_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                rs1_q   <= bus.instr[19:15];
                rs2_q   <= bus.instr[24:20];
                rd_q    <= bus.instr[11:7];
                ctrl_q  <= dec_ctrl;
                legal_q <= dec_legal;
            end
            if (state_q == ST_EXEC) begin
                a_q     <= bus.rf_rv1;
                b_q     <= bus.rf_rv2;
                wdata_q <= bus.alu_result;
                if (legal_q) cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Operands pass straight through in EXEC (the ALU result must settle in
    // that same cycle) and otherwise hold the last captured values.
    assign bus.alu_a       = (state_q == ST_EXEC) ? bus.rf_rv1 : a_q;
    assign bus.alu_b       = (state_q == ST_EXEC) ? bus.rf_rv2 : b_q;
    assign bus.alu_ctrl    = ctrl_q;
    assign bus.rf_rs1      = rs1_q;
    assign bus.rf_rs2      = rs2_q;
    assign bus.rf_rd       = rd_q;
    assign bus.rf_wdata    = wdata_q;
    assign bus.instr_count = cnt_q;
    assign bus.instr_ready = (state_q == ST_IDLE);
    assign bus.done        = (state_q == ST_WB);
    assign bus.illegal     = (state_q == ST_WB) && !legal_q;
    assign bus.rf_we       = (state_q == ST_WB) && legal_q && (rd_q != 5'd0);

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// Directed bench for rf_exec_ctrl: a behavioural regfile (registered read)
// and ALU surround the DUT; a vector table drives one instruction per
// 4-cycle slot, followed by a mid-instruction reset sequence.
module tb_rf_exec_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rf_init = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [XLEN-1:0] regs [32];

    rf_exec_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) ifc ();

    rf_exec_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // Regfile model: synchronous write, registered read.
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            regs[1] <= 32'd5;
            regs[2] <= 32'd3;
        end else if (ifc.rf_we) begin
            regs[ifc.rf_rd] <= ifc.rf_wdata;
        end
        ifc.rf_rv1 <= regs[ifc.rf_rs1];
        ifc.rf_rv2 <= regs[ifc.rf_rs2];
    end

    // ALU model.
    always_comb begin
        case (ifc.alu_ctrl)
            4'b0000: ifc.alu_result = ifc.alu_a & ifc.alu_b;
            4'b0001: ifc.alu_result = ifc.alu_a | ifc.alu_b;
            4'b0010: ifc.alu_result = ifc.alu_a + ifc.alu_b;
            4'b0011: ifc.alu_result = ifc.alu_a ^ ifc.alu_b;
            4'b0100: ifc.alu_result = ifc.alu_a << ifc.alu_b[4:0];
            4'b0101: ifc.alu_result = ifc.alu_a >> ifc.alu_b[4:0];
            4'b0110: ifc.alu_result = ifc.alu_a - ifc.alu_b;
            4'b0111: ifc.alu_result = {31'd0, $signed(ifc.alu_a) < $signed(ifc.alu_b)};
            4'b1000: ifc.alu_result = $unsigned($signed(ifc.alu_a) >>> ifc.alu_b[4:0]);
            default: ifc.alu_result = '0;
        endcase
    end

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  ctrl;
        logic        chk_ctrl;
        logic [31:0] a, b;
        logic        we;
        logic [31:0] wdata;
        logic        chk_data;
        logic        ill;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(logic [31:0] instr, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic [3:0] ctrl, logic chk_ctrl,
                                logic [31:0] a, logic [31:0] b, logic we,
                                logic [31:0] wdata, logic chk_data, logic ill,
                                logic [15:0] cnt);
        vec_t v;
        v.instr = instr; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.ctrl = ctrl; v.chk_ctrl = chk_ctrl; v.a = a; v.b = b; v.we = we;
        v.wdata = wdata; v.chk_data = chk_data; v.ill = ill; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One instruction slot: offer in cycle 0, check READ/EXEC/WB at negedges.
    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        chk({t, " ready_c0"}, 32'(ifc.instr_ready), 32'd1);
        ifc.instr = v.instr;
        ifc.instr_valid = 1'b1;
        @(negedge clk); // READ
        ifc.instr_valid = 1'b0;
        ifc.instr = '0;
        chk({t, " ready_read"}, 32'(ifc.instr_ready), 32'd0);
        chk({t, " rs1"}, 32'(ifc.rf_rs1), 32'(v.rs1));
        chk({t, " rs2"}, 32'(ifc.rf_rs2), 32'(v.rs2));
        chk({t, " done_read"}, 32'(ifc.done), 32'd0);
        if (v.chk_ctrl) chk({t, " ctrl_read"}, 32'(ifc.alu_ctrl), 32'(v.ctrl));
        @(negedge clk); // EXEC
        chk({t, " ready_exec"}, 32'(ifc.instr_ready), 32'd0);
        chk({t, " rs1_exec"}, 32'(ifc.rf_rs1), 32'(v.rs1));
        chk({t, " alu_a"}, ifc.alu_a, v.a);
        chk({t, " alu_b"}, ifc.alu_b, v.b);
        chk({t, " we_exec"}, 32'(ifc.rf_we), 32'd0);
        if (v.chk_ctrl) chk({t, " ctrl_exec"}, 32'(ifc.alu_ctrl), 32'(v.ctrl));
        @(negedge clk); // WB
        chk({t, " ready_wb"}, 32'(ifc.instr_ready), 32'd0);
        chk({t, " we"}, 32'(ifc.rf_we), 32'(v.we));
        chk({t, " rd"}, 32'(ifc.rf_rd), 32'(v.rd));
        chk({t, " done"}, 32'(ifc.done), 32'd1);
        chk({t, " illegal"}, 32'(ifc.illegal), 32'(v.ill));
        chk({t, " count"}, 32'(ifc.instr_count), 32'(v.cnt));
        if (v.chk_data) chk({t, " wdata"}, ifc.rf_wdata, v.wdata);
    endtask

    initial begin
        ifc.instr_valid = 1'b0;
        ifc.instr = '0;

        tbl[0]  = mk(32'h002081B3, 1, 2, 3,  4'b0010, 1, 5, 3, 1, 32'd8,  1, 0, 1);   // ADD x3,x1,x2
        tbl[1]  = mk(32'h40208233, 1, 2, 4,  4'b0110, 1, 5, 3, 1, 32'd2,  1, 0, 2);   // SUB x4,x1,x2
        tbl[2]  = mk(32'h001122B3, 2, 1, 5,  4'b0111, 1, 3, 5, 1, 32'd1,  1, 0, 3);   // SLT x5,x2,x1
        tbl[3]  = mk(32'h00208033, 1, 2, 0,  4'b0010, 1, 5, 3, 0, 32'd8,  1, 0, 4);   // ADD x0,x1,x2
        tbl[4]  = mk(32'h00208013, 1, 2, 0,  4'b0000, 0, 5, 3, 0, 32'd0,  0, 1, 4);   // opcode 0010011
        tbl[5]  = mk(32'h022083B3, 1, 2, 7,  4'b0000, 0, 5, 3, 0, 32'd0,  0, 1, 4);   // ADD with f7=01
        tbl[6]  = mk(32'h00318333, 3, 3, 6,  4'b0010, 1, 8, 8, 1, 32'd16, 1, 0, 5);   // ADD x6,x3,x3
        tbl[7]  = mk(32'h0020F433, 1, 2, 8,  4'b0000, 1, 5, 3, 1, 32'd1,  1, 0, 6);   // AND
        tbl[8]  = mk(32'h0020E4B3, 1, 2, 9,  4'b0001, 1, 5, 3, 1, 32'd7,  1, 0, 7);   // OR
        tbl[9]  = mk(32'h0020C533, 1, 2, 10, 4'b0011, 1, 5, 3, 1, 32'd6,  1, 0, 8);   // XOR
        tbl[10] = mk(32'h002095B3, 1, 2, 11, 4'b0100, 1, 5, 3, 1, 32'd40, 1, 0, 9);   // SLL
        tbl[11] = mk(32'h401006B3, 0, 1, 13, 4'b0110, 1, 0, 5, 1, 32'hFFFFFFFB, 1, 0, 10); // SUB x13,x0,x1
        tbl[12] = mk(32'h4026D733, 13, 2, 14, 4'b1000, 1, 32'hFFFFFFFB, 3, 1, 32'hFFFFFFFF, 1, 0, 11); // SRA
        tbl[13] = mk(32'h0026D7B3, 13, 2, 15, 4'b0101, 1, 32'hFFFFFFFB, 3, 1, 32'h1FFFFFFF, 1, 0, 12); // SRL

        // Reset state.
        repeat (2) @(negedge clk);
        rf_init = 1'b0;
        chk("rst ready", 32'(ifc.instr_ready), 32'd1);
        chk("rst we", 32'(ifc.rf_we), 32'd0);
        chk("rst done", 32'(ifc.done), 32'd0);
        chk("rst illegal", 32'(ifc.illegal), 32'd0);
        chk("rst count", 32'(ifc.instr_count), 32'd0);
        chk("rst ctrl", 32'(ifc.alu_ctrl), 32'b0010);
        chk("rst wdata", ifc.rf_wdata, 32'd0);
        chk("rst alu_a", ifc.alu_a, 32'd0);
        rst_n = 1'b1;

        // Idle hold: no valid, no progress.
        repeat (2) @(negedge clk);
        chk("idle ready", 32'(ifc.instr_ready), 32'd1);
        chk("idle done", 32'(ifc.done), 32'd0);

        for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

        @(negedge clk);
        chk("x0", regs[0], 32'd0);
        chk("x3", regs[3], 32'd8);
        chk("x4", regs[4], 32'd2);
        chk("x5", regs[5], 32'd1);
        chk("x6", regs[6], 32'd16);
        chk("x7 untouched", regs[7], 32'd0);
        chk("x14", regs[14], 32'hFFFFFFFF);
        chk("x15", regs[15], 32'h1FFFFFFF);
        chk("hold wdata", ifc.rf_wdata, 32'h1FFFFFFF);
        chk("hold alu_a", ifc.alu_a, 32'hFFFFFFFB);

        // Reset in EXEC of ADD x20,x1,x2: discarded, no write.
        ifc.instr = 32'h00208A33;
        ifc.instr_valid = 1'b1;
        @(negedge clk); // READ
        ifc.instr_valid = 1'b0;
        @(negedge clk); // EXEC
        rst_n = 1'b0;
        #1;
        chk("mid rst ready", 32'(ifc.instr_ready), 32'd1);
        chk("mid rst we", 32'(ifc.rf_we), 32'd0);
        chk("mid rst done", 32'(ifc.done), 32'd0);
        chk("mid rst count", 32'(ifc.instr_count), 32'd0);
        chk("mid rst rs1", 32'(ifc.rf_rs1), 32'd0);
        chk("mid rst rd", 32'(ifc.rf_rd), 32'd0);
        chk("mid rst alu_a", ifc.alu_a, 32'd0);
        chk("mid rst ctrl", 32'(ifc.alu_ctrl), 32'b0010);
        repeat (3) @(negedge clk);
        chk("mid rst x20", regs[20], 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post rst ready", 32'(ifc.instr_ready), 32'd1);
        chk("post rst count", 32'(ifc.instr_count), 32'd0);
        chk("post rst x20", regs[20], 32'd0);

        // Normal operation after reset: ADD x16,x1,x2.
        run_vec(mk(32'h00208833, 1, 2, 16, 4'b0010, 1, 5, 3, 1, 32'd8, 1, 0, 1), 99);
        @(negedge clk);
        chk("x16", regs[16], 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_exec_ctrl.md
Name: rf_exec_ctrl

Overview:
Initiator-side sequencer for the 32x32 register file. It accepts one RV32 R-type instruction per handshake and drives the register-file read addresses. It waits out the file's one-cycle registered read, presents the operands and an ALU control code to the external ALU, then issues the write-back (rd, data, regWrite). It sits between instruction supply and the regfile/ALU pair and is the sole driver of the regfile's control inputs.

Parameters:
XLEN, 32, data width of operands, results and rf_wdata
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept (IDLE only)
instr  in  32  R-type word: [31:25] funct7, [24:20] rs2, [19:15] rs1, [14:12] funct3, [11:7] rd, [6:0] opcode
rf_rs1  out  5  regfile read address 1
rf_rs2  out  5  regfile read address 2
rf_rd  out  5  regfile write address
rf_we  out  1  regfile regWrite
rf_wdata  out  XLEN  regfile write data
rf_rv1  in  XLEN  regfile read data 1 (registered in regfile)
rf_rv2  in  XLEN  regfile read data 2 (registered in regfile)
alu_a  out  XLEN  ALU operand A
alu_b  out  XLEN  ALU operand B
alu_ctrl  out  4  ALU operation code
alu_result  in  XLEN  combinational ALU result
done  out  1  one-cycle pulse: instruction retired or rejected
illegal  out  1  one-cycle pulse with done: instruction rejected, no write
instr_count  out  CNT_W  retired legal instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (async assert, sync release): state IDLE; instr_ready=1; rf_we=0; done=0; illegal=0; instr_count=0; rf_rs1/rf_rs2/rf_rd/rf_wdata/alu_a/alu_b=0; alu_ctrl=4'b0010. Reset mid-instruction discards it; no write is issued.
- FSM IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE: instr_ready=1. When instr_valid=1, latch instr and go to READ. instr_valid=0 holds IDLE.
- READ: rf_rs1/rf_rs2 driven from the latched instr and held through EXEC. The regfile samples them at the READ-ending edge.
- EXEC: rf_rv1/rf_rv2 are valid. alu_a=rf_rv1, alu_b=rf_rv2, alu_ctrl decoded. Capture alu_result into rf_wdata at the EXEC-ending edge.
- WB: rf_rd=rd. rf_we=1 for exactly this cycle, only if the instruction is legal and rd!=0. done=1 in WB. instr_count increments in WB for legal instructions, including rd=0.
- Latency: handshake in cycle 0, write edge at end of cycle 3, instr_ready high again in cycle 4. Throughput is 1 instruction per 4 cycles.
- Decode (opcode must be 7'b0110011):
  - ADD f7=00 f3=0 -> 0010
  - SUB f7=20 f3=0 -> 0110
  - AND f3=7 -> 0000
  - OR f3=6 -> 0001
  - XOR f3=4 -> 0011
  - SLT f3=2 -> 0111
  - SLL f3=1 -> 0100
  - SRL f7=00 f3=5 -> 0101
  - SRA f7=20 f3=5 -> 1000
  - Any other opcode/funct combination is illegal: the FSM still walks all states, rf_we stays 0, and illegal pulses with done in WB.
- Outputs other than rf_we/done/illegal are registered and hold their last value when idle.
- Back-to-back writes: a following instruction reading the just-written rd gets the new value, because the write edge precedes its READ.

Decomposition:
- Shared package rf_pkg: opcode constant OP_RTYPE; ALU code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SUB, ALU_SLT, ALU_SRA); FSM state encoding.
- One sub-module, rtype_decode: combinational instr -> {alu_ctrl, legal}. It is reused by the verification model.

Test Plan:
- Regfile model with x1=5, x2=3; ADD x3,x1,x2 (0x002081B3) -> rf_rs1=1 and rf_rs2=2 in READ; alu_ctrl=0010 in EXEC; rf_we=1, rf_rd=3, rf_wdata=8 in cycle 3; done=1; instr_count=1.
- SUB x4,x1,x2 (0x40208233) immediately after, then SLT x5,x2,x1 (0x001122B3) -> x4=2, x5=1; instr_ready low for 3 cycles after each accept.
- ADD x0,x1,x2 (0x00208033) -> rf_we stays 0, done=1, illegal=0, instr_count increments.
- Illegal word 0x00208013 (opcode 0010011) and funct7=0x01 ADD -> done=1, illegal=1, rf_we=0, instr_count unchanged.
- Dependent chain ADD x3,x1,x2 then ADD x6,x3,x3 -> x6=16.
- rst_n asserted in EXEC -> all outputs to reset values immediately; no rf_we pulse; instr_ready=1 after release; instr_count=0.
